// File: rtl/seq_detect_param_if.sv
// ----------------------------------------------------------------------------
// seq_detect_param_if
// Bundles the serial data, configuration and result signals of the
// parametrised pattern detector so that the detector and its driver connect
// through one port.
//   din_valid   : din is sampled on this edge when high
//   din         : serial data bit
//   cfg_we      : load cfg_pattern / cfg_mask on this edge
//   cfg_pattern : new pattern (W bits)
//   cfg_mask    : new compare mask, 1 = compare bit, 0 = don't care (W bits)
//   cnt_clr     : clear the match counter
//   hist        : most recent W bits, hist[0] = newest
//   match       : registered one-cycle match pulse
//   match_cnt   : saturating match count (CNT_W bits)
// master = source of stimulus/config, slave = the detector.
// ----------------------------------------------------------------------------
interface seq_detect_param_if #(
    parameter int W     = 4,
    parameter int CNT_W = 8
);
    logic             din_valid;
    logic             din;
    logic             cfg_we;
    logic [W-1:0]     cfg_pattern;
    logic [W-1:0]     cfg_mask;
    logic             cnt_clr;
    logic [W-1:0]     hist;
    logic             match;
    logic [CNT_W-1:0] match_cnt;

    modport master (
        output din_valid, din, cfg_we, cfg_pattern, cfg_mask, cnt_clr,
        input  hist, match, match_cnt
    );

    modport slave (
        input  din_valid, din, cfg_we, cfg_pattern, cfg_mask, cnt_clr,
        output hist, match, match_cnt
    );
endinterface

// File: rtl/seq_detect_param.sv
// ----------------------------------------------------------------------------
// seq_detect_param
// Serial bit-pattern detector. Each accepted bit is shifted into a W-bit
// history; a registered one-cycle match pulse is raised when the post-shift
// history equals a runtime-loadable pattern on the bits selected by a
// runtime-loadable mask. Overlapping or non-overlapping matching is chosen by
// the OVERLAP parameter. Matches are counted in a saturating counter.
// Ports:
//   clk   : rising-edge clock, sole clock domain
//   reset : synchronous, active-high; restores all state
//   bus   : seq_detect_param_if.slave (data, config, counter clear, results)
// Parameters: W (2..32), PATTERN / MASK (reset values of the config
// registers), OVERLAP (1 = overlapping matches), CNT_W (counter width).
// ----------------------------------------------------------------------------
module seq_detect_param #(
    parameter int           W       = 4,
    parameter logic [W-1:0] PATTERN = 4'b1101,
    parameter logic [W-1:0] MASK    = 4'b1111,
    parameter bit           OVERLAP = 1'b1,
    parameter int           CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    seq_detect_param_if.slave  bus
);
    // fill counts 0..W inclusive, so it needs room for the value W itself
    localparam int FW = $clog2(W + 1);

    logic [W-1:0]     hist_q;
    logic [W-1:0]     pat_q;
    logic [W-1:0]     mask_q;
    logic [FW-1:0]    fill_q;
    logic             match_q;
    logic [CNT_W-1:0] cnt_q;

    logic [W-1:0]     hist_d;
    logic [FW-1:0]    fill_inc;
    logic             hit;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        hist_d   = {hist_q[W-2:0], bus.din};
        fill_inc = (fill_q == FW'(W)) ? fill_q : fill_q + FW'(1);
        // cfg_we wins over din_valid: the bit presented with a config load is dropped
        hit      = bus.din_valid && !bus.cfg_we && (fill_inc == FW'(W)) &&
                   (((hist_d ^ pat_q) & mask_q) == '0);
    end

    // Clearing and a simultaneous new match combine to a count of one
    always_comb begin
        cnt_d = cnt_q;
        if (hit) begin
            if (bus.cnt_clr)
                cnt_d = CNT_W'(1);
            else if (cnt_q != '1)
                cnt_d = cnt_q + CNT_W'(1);
        end else if (bus.cnt_clr) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q  <= '0;
            pat_q   <= PATTERN;
            mask_q  <= MASK;
            fill_q  <= '0;
            match_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (bus.cfg_we) begin
                pat_q  <= bus.cfg_pattern;
                mask_q <= bus.cfg_mask;
                fill_q <= '0;
            end else if (bus.din_valid) begin
                hist_q <= hist_d;
                // Non-overlapping mode restarts the fill so W fresh bits are needed
                if (!OVERLAP && hit)
                    fill_q <= '0;
                else
                    fill_q <= fill_inc;
            end
            match_q <= hit;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.hist      = hist_q;
    assign bus.match     = match_q;
    assign bus.match_cnt = cnt_q;
endmodule

// File: tb/tb_seq_detect_param.sv
module tb_seq_detect_param;
    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    // a: defaults (overlap), n: non-overlap, c: 2-bit counter, w: 8-bit A5
    seq_detect_param_if #(.W(4), .CNT_W(8)) if_a ();
    seq_detect_param_if #(.W(4), .CNT_W(8)) if_n ();
    seq_detect_param_if #(.W(4), .CNT_W(2)) if_c ();
    seq_detect_param_if #(.W(8), .CNT_W(8)) if_w ();

    seq_detect_param u_a (.clk(clk), .reset(reset), .bus(if_a));
    seq_detect_param #(.OVERLAP(1'b0)) u_n (.clk(clk), .reset(reset), .bus(if_n));
    seq_detect_param #(.CNT_W(2)) u_c (.clk(clk), .reset(reset), .bus(if_c));
    seq_detect_param #(.W(8), .PATTERN(8'hA5), .MASK(8'hFF), .OVERLAP(1'b1), .CNT_W(8))
        u_w (.clk(clk), .reset(reset), .bus(if_w));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        if_a.din_valid = 0; if_a.din = 0; if_a.cfg_we = 0; if_a.cnt_clr = 0;
        if_n.din_valid = 0; if_n.din = 0; if_n.cfg_we = 0; if_n.cnt_clr = 0;
        if_c.din_valid = 0; if_c.din = 0; if_c.cfg_we = 0; if_c.cnt_clr = 0;
        if_w.din_valid = 0; if_w.din = 0; if_w.cfg_we = 0; if_w.cnt_clr = 0;
    endtask

    // inst: 0=a 1=n 2=c 3=w
    task automatic drv(input int inst, input logic v, input logic d, input logic clr);
        idle_all();
        case (inst)
            0: begin if_a.din_valid = v; if_a.din = d; if_a.cnt_clr = clr; end
            1: begin if_n.din_valid = v; if_n.din = d; if_n.cnt_clr = clr; end
            2: begin if_c.din_valid = v; if_c.din = d; if_c.cnt_clr = clr; end
            default: begin if_w.din_valid = v; if_w.din = d; if_w.cnt_clr = clr; end
        endcase
        tick();
    endtask

    task automatic cfg_a(input logic [3:0] pat, input logic [3:0] msk, input logic v, input logic d);
        idle_all();
        if_a.cfg_we = 1; if_a.cfg_pattern = pat; if_a.cfg_mask = msk;
        if_a.din_valid = v; if_a.din = d;
        tick();
        idle_all();
    endtask

    task automatic do_reset();
        idle_all();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (if_a.hist !== 4'b0000) begin fails++; $display("FAIL reset_hist got %b exp 0000", if_a.hist); end
        tests++; if (if_a.match !== 1'b0) begin fails++; $display("FAIL reset_match got %b exp 0", if_a.match); end
        tests++; if (if_a.match_cnt !== 8'd0) begin fails++; $display("FAIL reset_cnt got %0d exp 0", if_a.match_cnt); end
        tests++; if (if_w.hist !== 8'h00) begin fails++; $display("FAIL reset_hist_w got %h exp 00", if_w.hist); end
    endtask

    task automatic test_basic();
        logic [3:0] bits = 4'b1011; // sent LSB first: 1,1,0,1
        logic [3:0] expm = 4'b1000;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drv(0, 1, bits[i], 0);
            tests++;
            if (if_a.match !== expm[i]) begin fails++; $display("FAIL basic_match bit%0d got %b exp %b", i+1, if_a.match, expm[i]); end
        end
        tests++; if (if_a.hist !== 4'b1101) begin fails++; $display("FAIL basic_hist got %b exp 1101", if_a.hist); end
        tests++; if (if_a.match_cnt !== 8'd1) begin fails++; $display("FAIL basic_cnt got %0d exp 1", if_a.match_cnt); end
        drv(0, 0, 0, 0);
        tests++; if (if_a.match !== 1'b0) begin fails++; $display("FAIL basic_pulse got %b exp 0", if_a.match); end
    endtask

    task automatic test_overlap();
        logic [6:0] s7  = 7'b1011011;   // 1,1,0,1,1,0,1 LSB first
        logic [6:0] ea  = 7'b1001000;   // overlap: after bits 4 and 7
        logic [6:0] en  = 7'b0001000;   // non-overlap: after bit 4 only
        logic [7:0] s8  = 8'b10111011;  // 1,1,0,1,1,1,0,1
        logic [7:0] en8 = 8'b10001000;  // after bits 4 and 8
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drv(0, 1, s7[i], 0);
            tests++;
            if (if_a.match !== ea[i]) begin fails++; $display("FAIL ovl_match bit%0d got %b exp %b", i+1, if_a.match, ea[i]); end
        end
        tests++; if (if_a.match_cnt !== 8'd2) begin fails++; $display("FAIL ovl_cnt got %0d exp 2", if_a.match_cnt); end
        for (int i = 0; i < 7; i++) begin
            drv(1, 1, s7[i], 0);
            tests++;
            if (if_n.match !== en[i]) begin fails++; $display("FAIL novl_match bit%0d got %b exp %b", i+1, if_n.match, en[i]); end
        end
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drv(1, 1, s8[i], 0);
            tests++;
            if (if_n.match !== en8[i]) begin fails++; $display("FAIL novl8_match bit%0d got %b exp %b", i+1, if_n.match, en8[i]); end
        end
        tests++; if (if_n.match_cnt !== 8'd2) begin fails++; $display("FAIL novl8_cnt got %0d exp 2", if_n.match_cnt); end
    endtask

    task automatic test_gaps();
        do_reset();
        drv(0, 1, 1, 0);
        drv(0, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            drv(0, 0, 1, 0);
            tests++;
            if (if_a.match !== 1'b0 || if_a.hist !== 4'b0011) begin
                fails++; $display("FAIL gap_hold cyc%0d got m=%b h=%b exp m=0 h=0011", i, if_a.match, if_a.hist);
            end
        end
        drv(0, 1, 0, 0);
        tests++; if (if_a.match !== 1'b0) begin fails++; $display("FAIL gap_bit3 got %b exp 0", if_a.match); end
        drv(0, 1, 1, 0);
        tests++; if (if_a.match !== 1'b1) begin fails++; $display("FAIL gap_bit4 got %b exp 1", if_a.match); end
        do_reset();
        drv(0, 1, 1, 0);
        drv(0, 1, 1, 0);
        drv(0, 1, 0, 0);
        do_reset();
        drv(0, 1, 1, 0);
        tests++;
        if (if_a.match !== 1'b0 || if_a.hist !== 4'b0001) begin
            fails++; $display("FAIL rst_midstream got m=%b h=%b exp m=0 h=0001", if_a.match, if_a.hist);
        end
    endtask

    task automatic test_cfg();
        do_reset();
        cfg_a(4'b0000, 4'b1111, 1, 1); // bit presented with cfg_we is dropped
        tests++;
        if (if_a.hist !== 4'b0000 || if_a.match !== 1'b0) begin
            fails++; $display("FAIL cfg_drop got m=%b h=%b exp m=0 h=0000", if_a.match, if_a.hist);
        end
        for (int i = 0; i < 4; i++) begin
            drv(0, 1, 0, 0);
            tests++;
            if (if_a.match !== (i == 3)) begin fails++; $display("FAIL cfg_zero bit%0d got %b exp %b", i+1, if_a.match, i == 3); end
        end
        cfg_a(4'b1001, 4'b1001, 0, 0);
        for (int i = 0; i < 4; i++) begin
            drv(0, 1, 1, 0);
            tests++;
            if (if_a.match !== (i == 3)) begin fails++; $display("FAIL cfg_mask bit%0d got %b exp %b", i+1, if_a.match, i == 3); end
        end
        cfg_a(4'b0101, 4'b0000, 0, 0);
        for (int i = 0; i < 5; i++) begin
            drv(0, 1, i[0], 0);
            tests++;
            if (if_a.match !== (i >= 3)) begin fails++; $display("FAIL cfg_dc bit%0d got %b exp %b", i+1, if_a.match, i >= 3); end
        end
    endtask

    task automatic test_counter();
        logic [3:0] first = 4'b1011;
        logic [2:0] rep   = 3'b101;   // 1,0,1 re-completes 1101 in overlap mode
        do_reset();
        for (int i = 0; i < 4; i++) drv(2, 1, first[i], 0);
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 3; i++) drv(2, 1, rep[i], 0);
        tests++; if (if_c.match_cnt !== 2'd3) begin fails++; $display("FAIL cnt_sat got %0d exp 3", if_c.match_cnt); end
        drv(2, 1, 1, 0);
        drv(2, 1, 0, 0);
        drv(2, 1, 1, 1);
        tests++;
        if (if_c.match !== 1'b1 || if_c.match_cnt !== 2'd1) begin
            fails++; $display("FAIL cnt_clr_match got m=%b c=%0d exp m=1 c=1", if_c.match, if_c.match_cnt);
        end
        drv(2, 0, 0, 1);
        tests++;
        if (if_c.match_cnt !== 2'd0 || if_c.hist !== 4'b1101) begin
            fails++; $display("FAIL cnt_clr_alone got c=%0d h=%b exp c=0 h=1101", if_c.match_cnt, if_c.hist);
        end
    endtask

    task automatic test_random();
        logic [7:0] mh = '0;
        int         mf = 0;
        logic       em;
        int         ec = 0;
        logic       v, d;
        int         nm = 0;
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            v = ($urandom_range(0, 3) != 0);
            d = $urandom_range(0, 1);
            em = 1'b0;
            if (v) begin
                mh = {mh[6:0], d};
                if (mf < 8) mf++;
                em = (mf == 8) && (mh == 8'hA5);
            end
            if (em) begin nm++; if (ec < 255) ec++; end
            drv(3, v, d, 0);
            tests++;
            if (if_w.match !== em || if_w.hist !== mh || if_w.match_cnt !== ec[7:0]) begin
                fails++;
                $display("FAIL rand cyc%0d got m=%b h=%h c=%0d exp m=%b h=%h c=%0d",
                         i, if_w.match, if_w.hist, if_w.match_cnt, em, mh, ec);
            end
        end
        $display("[TB] random stream produced %0d matches", nm);
    endtask

    initial begin
        reset = 1'b0;
        idle_all();
        if_a.cfg_pattern = '0; if_a.cfg_mask = '0;
        if_n.cfg_pattern = '0; if_n.cfg_mask = '0;
        if_c.cfg_pattern = '0; if_c.cfg_mask = '0;
        if_w.cfg_pattern = '0; if_w.cfg_mask = '0;
        test_reset();
        test_basic();
        test_overlap();
        test_gaps();
        test_cfg();
        test_counter();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
